// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

   localparam int unsigned LINE_W   = 128;
   localparam int unsigned OFFSET_W = 4;
   localparam int unsigned ADDR_W   = 32;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      MISS,
      RESP
   } state_e;

   // Line-aligned address: the offset bits inside a 128-bit line forced to zero.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      return addr & ~(ADDR_W'((1 << OFFSET_W) - 1));
   endfunction

endpackage

// File: rtl/icache_ram.sv
// Data, tag and valid storage: one synchronous read port, one write port,
// and a bulk clear of the valid bits.
module icache_ram
   import icache_pkg::*;
#(
   parameter int unsigned LINES = 32,
   parameter int unsigned IDX_W = $clog2(LINES),
   parameter int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic              rd_en_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [LINE_W-1:0] rd_data_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic              rd_valid_o,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic [TAG_W-1:0]  wr_tag_i
);

   logic [LINE_W-1:0] data_q [LINES];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINES-1:0]  valid_q;

   logic [LINE_W-1:0] rd_data_q;
   logic [TAG_W-1:0]  rd_tag_q;
   logic              rd_valid_q;

   // Line fill: data and tag have no reset, their contents are don't-care until valid.
   always_ff @(posedge clk) begin
      if (we_i) begin
         data_q[wr_idx_i] <= wr_data_i;
         tag_q[wr_idx_i]  <= wr_tag_i;
      end
   end

   // Valid bits: cleared in the same edge the clear is sampled, set on fill.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Synchronous read: result is available the cycle after rd_en_i.
   always_ff @(posedge clk) begin
      if (rd_en_i) begin
         rd_data_q  <= data_q[rd_idx_i];
         rd_tag_q   <= tag_q[rd_idx_i];
         rd_valid_q <= valid_q[rd_idx_i];
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_tag_o   = rd_tag_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: IFQ fetch front end with a single
// outstanding line fill and abort handling.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned LINES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              cache_rd_en,
   input  logic              cache_abort,
   output logic [LINE_W-1:0] dout,
   output logic              dout_valid,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_data,
   input  logic              mem_valid
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [LINE_W-1:0] dout_q, dout_d;
   logic              dv_q, dv_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              aborted_q, aborted_d;

   logic              ram_rd_en;
   logic [LINE_W-1:0] ram_rd_data;
   logic [TAG_W-1:0]  ram_rd_tag;
   logic              ram_rd_valid;
   logic              ram_we;
   logic              hit;

   icache_ram #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_ram (
      .clk        (clk),
      .clr_i      (~rst),
      .rd_en_i    (ram_rd_en),
      .rd_idx_i   (pc_in[OFFSET_W +: IDX_W]),
      .rd_data_o  (ram_rd_data),
      .rd_tag_o   (ram_rd_tag),
      .rd_valid_o (ram_rd_valid),
      .we_i       (ram_we),
      .wr_idx_i   (pc_q[OFFSET_W +: IDX_W]),
      .wr_data_i  (mem_data),
      .wr_tag_i   (pc_q[ADDR_W-1 -: TAG_W])
   );

   assign hit = ram_rd_valid && (ram_rd_tag == pc_q[ADDR_W-1 -: TAG_W]);

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         dout_q    <= '0;
         dv_q      <= 1'b0;
         addr_q    <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         dout_q    <= dout_d;
         dv_q      <= dv_d;
         addr_q    <= addr_d;
         aborted_q <= aborted_d;
      end
   end

   // Next-state and datapath control for the fetch/fill sequence.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      dout_d    = dout_q;
      dv_d      = 1'b0;
      addr_d    = addr_q;
      aborted_d = aborted_q;
      ram_rd_en = 1'b0;
      ram_we    = 1'b0;

      unique case (state_q)
         IDLE: begin
            aborted_d = 1'b0;
            if (cache_rd_en && !cache_abort) begin
               pc_d      = line_base(pc_in);
               ram_rd_en = 1'b1;
               state_d   = LOOKUP;
            end
         end

         LOOKUP: begin
            if (cache_abort) begin
               state_d = IDLE;
            end else if (hit) begin
               dout_d  = ram_rd_data;
               dv_d    = 1'b1;
               state_d = IDLE;
            end else begin
               addr_d  = pc_q;
               state_d = MISS;
            end
         end

         MISS: begin
            if (cache_abort) begin
               aborted_d = 1'b1;
            end
            if (mem_valid) begin
               ram_we  = 1'b1;
               state_d = RESP;
               // The response is decided here so an abort in the fill cycle
               // itself still suppresses it; dout stays put when suppressed.
               if (!(aborted_q || cache_abort)) begin
                  dout_d = mem_data;
                  dv_d   = 1'b1;
               end
            end
         end

         RESP: begin
            aborted_d = 1'b0;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign mem_req    = (state_q == MISS);
   assign mem_addr   = addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected responses and fill
// requests; a negedge monitor pops and compares whenever the DUT presents them.
module tb_icache;

   logic         clk;
   logic         rst;
   logic [31:0]  pc_in;
   logic         cache_rd_en;
   logic         cache_abort;
   logic [127:0] dout;
   logic         dout_valid;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic [127:0] mem_data;
   logic         mem_valid;

   icache #(.LINES(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .cache_rd_en (cache_rd_en),
      .cache_abort (cache_abort),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_valid   (mem_valid)
   );

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } memreq_t;

   resp_t   exp_q[$];
   memreq_t mem_q[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
   localparam logic [127:0] D1 = 128'h1111_0001_1111_0002_1111_0003_1111_0004;
   localparam logic [127:0] D2 = 128'h2222_0001_2222_0002_2222_0003_2222_0004;
   localparam logic [127:0] D3 = 128'h3333_0001_3333_0002_3333_0003_3333_0004;
   localparam logic [127:0] D4 = 128'h4444_0001_4444_0002_4444_0003_4444_0004;
   localparam logic [127:0] D5 = 128'h5555_0001_5555_0002_5555_0003_5555_0004;
   localparam logic [127:0] D6 = 128'h6666_0001_6666_0002_6666_0003_6666_0004;
   localparam logic [127:0] D8 = 128'h8888_0001_8888_0002_8888_0003_8888_0004;
   localparam logic [127:0] D9 = 128'h9999_0001_9999_0002_9999_0003_9999_0004;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: responses, fill requests, address stability and dout hold.
   logic [127:0] last_dout = '0;
   logic         mreq_prev = 1'b0;
   logic [31:0]  cur_addr  = '0;

   always @(negedge clk) begin
      if (!rst) begin
         last_dout = '0;
         mreq_prev = 1'b0;
      end else begin
         if (dout_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_dout_valid", 1, 0);
            end else begin
               resp_t e;
               e = exp_q.pop_front();
               check("dout", dout, e.data);
               check("dout_valid_cycle", cyc, e.cyc);
            end
            last_dout = dout;
         end else begin
            check("dout_hold", dout, last_dout);
         end

         if (mem_req && !mreq_prev) begin
            if (mem_q.size() == 0) begin
               check("unexpected_mem_req", 1, 0);
            end else begin
               memreq_t m;
               m = mem_q.pop_front();
               cur_addr = m.addr;
               check("mem_req_cycle", cyc, m.cyc);
            end
         end
         if (mem_req) check("mem_addr", mem_addr, cur_addr);
         mreq_prev = mem_req;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Accept a request in the current cycle; returns one cycle later (LOOKUP).
   task automatic req(input logic [31:0] pc);
      cache_rd_en = 1'b1;
      pc_in       = pc;
      tick();
      cache_rd_en = 1'b0;
   endtask

   // Hit: dout_valid two cycles after accept; returns in that dout_valid cycle.
   task automatic hit(input logic [31:0] pc, input logic [127:0] d);
      exp_q.push_back('{data: d, cyc: cyc + 2});
      req(pc);
      tick();
   endtask

   // Miss: mem_req rises two cycles after accept; wait_n cycles of mem_req
   // before mem_valid; abort_at < 0 means no abort, otherwise the MISS-cycle
   // offset where cache_abort pulses (== wait_n means the mem_valid cycle).
   task automatic miss(input logic [31:0] pc, input logic [31:0] exp_addr,
                       input logic [127:0] d, input int wait_n, input int abort_at);
      mem_q.push_back('{addr: exp_addr, cyc: cyc + 2});
      req(pc);
      tick();
      for (int i = 0; i < wait_n; i++) begin
         if (i == abort_at) cache_abort = 1'b1;
         tick();
         cache_abort = 1'b0;
      end
      if (abort_at == wait_n) cache_abort = 1'b1;
      mem_valid = 1'b1;
      mem_data  = d;
      if (abort_at < 0) exp_q.push_back('{data: d, cyc: cyc + 1});
      tick();
      mem_valid   = 1'b0;
      cache_abort = 1'b0;
      mem_data    = JUNK;
      tick();
   endtask

   task automatic abort_lookup(input logic [31:0] pc);
      req(pc);
      cache_abort = 1'b1;
      tick();
      cache_abort = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      rst         = 1'b0;
      pc_in       = '0;
      cache_rd_en = 1'b0;
      cache_abort = 1'b0;
      mem_data    = JUNK;
      mem_valid   = 1'b0;
      tick();
      tick();
      check("rst_dout", dout, '0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      rst = 1'b1;
      tick();

      // Cold miss, then hit on another word of the same line.
      miss(32'h0000_0010, 32'h0000_0010, D1, 3, -1);
      tick();
      hit(32'h0000_001C, D1);
      tick();

      // Second line, then back-to-back hits accepted in the dout_valid cycle.
      miss(32'h0000_0020, 32'h0000_0020, D2, 1, -1);
      hit(32'h0000_0010, D1);
      hit(32'h0000_0024, D2);
      tick();

      // Conflict on index 1: 0x210 evicts 0x10, which then misses again.
      miss(32'h0000_0210, 32'h0000_0210, D3, 2, -1);
      miss(32'h0000_0010, 32'h0000_0010, D4, 0, -1);

      // Abort while waiting in MISS: no response, but the line is filled.
      miss(32'h0000_0300, 32'h0000_0300, D5, 3, 1);
      hit(32'h0000_0300, D5);
      tick();

      // Abort in the mem_valid cycle itself.
      miss(32'h0000_0404, 32'h0000_0400, D6, 2, 2);
      hit(32'h0000_0408, D6);
      tick();

      // Abort in LOOKUP: on a hit line and on a missing line, nothing comes out.
      abort_lookup(32'h0000_0020);
      abort_lookup(32'h0000_0500);

      // Abort in IDLE alone, and together with a request: both ignored.
      cache_abort = 1'b1;
      tick();
      cache_rd_en = 1'b1;
      pc_in       = 32'h0000_0020;
      tick();
      cache_rd_en = 1'b0;
      cache_abort = 1'b0;
      tick();
      tick();

      // Abort coinciding with the dout_valid pulse does not cancel it.
      hit(32'h0000_0020, D2);
      cache_abort = 1'b1;
      tick();
      cache_abort = 1'b0;
      tick();

      // mem_valid outside MISS is ignored; line 1 still holds D4.
      mem_valid = 1'b1;
      mem_data  = JUNK;
      tick();
      mem_valid = 1'b0;
      hit(32'h0000_0010, D4);
      tick();

      // Reset in the middle of a miss.
      mem_q.push_back('{addr: 32'h0000_0600, cyc: cyc + 2});
      req(32'h0000_0600);
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_mem_req", mem_req, 0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_dout_valid", dout_valid, 0);
      mem_valid = 1'b1;
      mem_data  = JUNK;
      tick();
      mem_valid = 1'b0;
      tick();
      tick();
      miss(32'h0000_0600, 32'h0000_0600, D8, 1, -1);
      miss(32'h0000_0010, 32'h0000_0010, D9, 0, -1);

      for (int i = 0; i < 4; i++) tick();
      check("resp_queue_drained", exp_q.size(), 0);
      check("mem_queue_drained", mem_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
